// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port memory between three requesters:
//   port 0 : debug / program loader (always highest priority)
//   port 1 : CPU data access (load/store)
//   port 2 : CPU instruction fetch
//
// Each access is sequenced as request -> ISSUE (one cycle, mem_en=1, gnt
// pulse) -> optional WAIT (reads only, RD_LAT cycles) -> rvalid pulse with
// rdata passed through from mem_rdata. Writes complete in their ISSUE cycle,
// and the next arbitration happens in that same cycle, so writes from
// different ports can go back to back.
//
// Configuration macro ARB_RR_EN:
//   undefined : fixed priority 0 > 1 > 2, and fetch (port 2) is promoted to
//               0 > 2 > 1 after STARVE_MAX consecutive lost arbitrations.
//   defined   : ports 1 and 2 alternate round-robin below port 0; the
//               starvation counter is removed and STARVE_MAX is unused.
//
// Ports:
//   CLK, rst_n                   clock (rising edge), async active-low reset
//   req, we [2:0]                per-port request / write enable
//   addr0..2, wdata0..2          per-port address / write data
//   gnt, rvalid [2:0]            per-port grant pulse / read-data-valid pulse
//   rdata                        read data shared by all ports
//   mem_en, mem_we, mem_addr,
//   mem_wdata, mem_rdata         memory macro interface
//   cpu_stall                    stall to the CPU while port 1/2 work is open
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 8
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic [2:0]        req,
  input  logic [2:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [DATA_W-1:0] wdata2,
  output logic [2:0]        gnt,
  output logic [2:0]        rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_stall
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  owner;       // port currently in ISSUE/WAIT
  logic [2:0]  owner_oh;
  logic [2:0]  lat_cnt;     // remaining WAIT cycles, 1 means final
  logic        last_wait;
  logic        arb_point;
  logic [2:0]  req_m;
  logic        win_valid;
  logic [1:0]  win_idx;
  logic        promote;     // port 2 ranks above port 1 this arbitration

  assign owner_oh  = 3'b001 << owner;
  assign last_wait = (state == WAIT) && (lat_cnt == 3'd1);

  // The memory is free again in a write's ISSUE cycle and in the final WAIT
  // cycle of a read (the read data is on the bus but the port can be reused).
  assign arb_point = (state == IDLE) || ((state == ISSUE) && mem_we) || last_wait;

  // The port being granted this cycle still holds req; hide it so it is not
  // granted twice for one access.
  assign req_m = req & ~gnt;

  // ---------------------------------------------------------------------------
  // Priority state: starvation counter or round-robin pointer
  // ---------------------------------------------------------------------------
`ifdef ARB_RR_EN
  logic last_was_2;   // last granted of {1,2} was port 2

  assign promote = !last_was_2;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      last_was_2 <= 1'b1;   // port 1 goes first after reset
    end else if (arb_point && win_valid && (win_idx != 2'd0)) begin
      last_was_2 <= (win_idx == 2'd2);
    end
  end
`else
  localparam int STARVE_W = $clog2(STARVE_MAX + 1);

  logic [STARVE_W-1:0] starve_cnt;

  assign promote = (starve_cnt == STARVE_W'(STARVE_MAX));

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (arb_point) begin
      if (!req_m[2] || (win_valid && (win_idx == 2'd2))) begin
        starve_cnt <= '0;
      end else if (!promote) begin
        starve_cnt <= starve_cnt + STARVE_W'(1);
      end
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Winner selection
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default before any branch;
    // a path that leaves one unassigned would infer a latch.
    win_valid = |req_m;
    win_idx   = 2'd0;
    if (req_m[0]) begin
      win_idx = 2'd0;
    end else if (promote) begin
      win_idx = req_m[2] ? 2'd2 : 2'd1;
    end else begin
      win_idx = req_m[1] ? 2'd1 : 2'd2;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    state_nxt = win_valid ? ISSUE : IDLE;
      ISSUE:   begin
        if (mem_we) begin
          state_nxt = win_valid ? ISSUE : IDLE;
        end else begin
          state_nxt = WAIT;
        end
      end
      WAIT:    begin
        if (last_wait) begin
          state_nxt = win_valid ? ISSUE : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_en = (state == ISSUE);
    gnt    = mem_en ? owner_oh : 3'b000;
    rvalid = last_wait ? owner_oh : 3'b000;
    rdata  = (|rvalid) ? mem_rdata : '0;
  end

  // ---------------------------------------------------------------------------
  // Captured access and read latency counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      owner     <= 2'd0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      lat_cnt   <= 3'd0;
    end else begin
      if (arb_point && win_valid) begin
        owner <= win_idx;
        unique case (win_idx)
          2'd0: begin
            mem_we    <= we[0];
            mem_addr  <= addr0;
            mem_wdata <= wdata0;
          end
          2'd1: begin
            mem_we    <= we[1];
            mem_addr  <= addr1;
            mem_wdata <= wdata1;
          end
          default: begin
            mem_we    <= we[2];
            mem_addr  <= addr2;
            mem_wdata <= wdata2;
          end
        endcase
      end
      if ((state == ISSUE) && !mem_we) begin
        lat_cnt <= 3'(RD_LAT);
      end else if (state == WAIT) begin
        lat_cnt <= lat_cnt - 3'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // CPU stall: a CPU port is busy while it requests or while its read is in
  // flight (the requester drops req after gnt); the completing cycle is free.
  // ---------------------------------------------------------------------------
  logic       read_pend;
  logic [1:0] cpu_busy;
  logic [1:0] cpu_done;

  assign read_pend = ((state == ISSUE) && !mem_we) || (state == WAIT);
  assign cpu_busy  = req[2:1] | (read_pend ? owner_oh[2:1] : 2'b00);
  assign cpu_done  = (gnt[2:1] & {2{mem_we}}) | rvalid[2:1];
  assign cpu_stall = |(cpu_busy & ~cpu_done);

endmodule
